// File: rtl/phase_meter_pkg.sv
// Shared types and helpers for the phase-meter measurement sequencer.
package phase_meter_pkg;

  // Default width of the phase count.
  localparam int unsigned CNT_W_DEF = 32;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSettle,
    StGate,
    StCapture,
    StOutput
  } sched_state_t;

  // Width of a channel index for n channel pairs (never below 1 bit).
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_meas_sched_if.sv
// Bundle of control, front-end and result signals around phase_meas_sched.
// master: the sequencer; slave: the surrounding datapath / host.
interface phase_meas_sched_if
  import phase_meter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF
);
  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic              start;
  logic              cont;
  logic [NUM_CH-1:0] ch_mask;
  logic [CH_W-1:0]   ch_sel;
  logic              meas_clr;
  logic              meas_gate;
  logic [CNT_W-1:0]  meas_cnt;
  logic              res_valid;
  logic              res_ready;
  logic [CH_W-1:0]   res_ch;
  logic [CNT_W-1:0]  res_cnt;
  logic              busy;
  logic              drop;

  modport master (
    input  start, cont, ch_mask, meas_cnt, res_ready,
    output ch_sel, meas_clr, meas_gate, res_valid, res_ch, res_cnt, busy, drop
  );

  modport slave (
    output start, cont, ch_mask, meas_cnt, res_ready,
    input  ch_sel, meas_clr, meas_gate, res_valid, res_ch, res_cnt, busy, drop
  );

endinterface

// File: rtl/phase_sched_chsel.sv
// Channel priority finder: next enabled channel above the current index in
// the sweep mask (with wrap flag), and the lowest enabled channel of a new mask.
module phase_sched_chsel
  import phase_meter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] sweep_mask,
  input  logic [CH_W-1:0]   cur,
  input  logic [NUM_CH-1:0] new_mask,
  output logic [CH_W-1:0]   next_ch,
  output logic              wrap,
  output logic [CH_W-1:0]   first_ch,
  output logic              first_valid
);

  // Scan downward so the lowest qualifying index is the one that sticks.
  always_comb begin
    next_ch     = '0;
    wrap        = 1'b1;
    first_ch    = '0;
    first_valid = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (sweep_mask[i] && (i > int'(cur))) begin
        next_ch = CH_W'(i);
        wrap    = 1'b0;
      end
      if (new_mask[i]) begin
        first_ch    = CH_W'(i);
        first_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_meas_sched.sv
// Phase measurement sequencer: sweeps enabled channel pairs, issuing
// clear / settle / gate / capture per channel and handing each count
// downstream over valid/ready.
// Optional feature macro: PHASE_SCHED_TIMEOUT_EN (result-accept timeout
// with sticky drop flag); when undefined OUTPUT waits forever, drop=0.
module phase_meas_sched
  import phase_meter_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SETTLE_CYCLES  = 10,
  parameter int unsigned GATE_CYCLES    = 400_000_000,
  parameter int unsigned CAP_CYCLES     = 2,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic                sys_clk,
  input logic                rst,
  phase_meas_sched_if.master bus
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);
  localparam int unsigned TMAX = umax(umax(SETTLE_CYCLES, GATE_CYCLES),
                                      umax(CAP_CYCLES, TIMEOUT_CYCLES));
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef logic [TW-1:0] tcnt_t;

  sched_state_t      state_q, state_d;
  tcnt_t             cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              clr_q, gate_q, valid_q, busy_q;
  logic [CH_W-1:0]   res_ch_q;
  logic [CNT_W-1:0]  res_cnt_q;
  logic              capture;
  logic              advance;
  logic              drop_clr;
  logic [CH_W-1:0]   next_ch, first_ch;
  logic              wrap, first_valid;

  phase_sched_chsel #(
    .NUM_CH (NUM_CH)
  ) u_chsel (
    .sweep_mask  (mask_q),
    .cur         (ch_q),
    .new_mask    (bus.ch_mask),
    .next_ch     (next_ch),
    .wrap        (wrap),
    .first_ch    (first_ch),
    .first_valid (first_valid)
  );

`ifdef PHASE_SCHED_TIMEOUT_EN
  logic drop_q, drop_set;
`endif

  // Next-state, cycle counter reload and channel/mask stepping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - tcnt_t'(1) : cnt_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    capture  = 1'b0;
    advance  = 1'b0;
    drop_clr = 1'b0;
`ifdef PHASE_SCHED_TIMEOUT_EN
    drop_set = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // A start with an empty mask is ignored outright.
        if (bus.start && first_valid) begin
          state_d  = StClear;
          ch_d     = first_ch;
          mask_d   = bus.ch_mask;
          drop_clr = 1'b1;
        end
      end
      StClear: begin
        state_d = StSettle;
        cnt_d   = tcnt_t'(SETTLE_CYCLES - 1);
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StGate;
          cnt_d   = tcnt_t'(GATE_CYCLES - 1);
        end
      end
      StGate: begin
        if (cnt_q == '0) begin
          state_d = StCapture;
          cnt_d   = tcnt_t'(CAP_CYCLES - 1);
        end
      end
      StCapture: begin
        if (cnt_q == '0) begin
          state_d = StOutput;
          capture = 1'b1;
          cnt_d   = tcnt_t'(TIMEOUT_CYCLES - 1);
        end
      end
      StOutput: begin
        if (valid_q && bus.res_ready) begin
          advance = 1'b1;
`ifdef PHASE_SCHED_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          advance  = 1'b1;
          drop_set = 1'b1;
`endif
        end
        if (advance) begin
          if (!wrap) begin
            state_d = StClear;
            ch_d    = next_ch;
          end else if (bus.cont && first_valid) begin
            state_d = StClear;
            ch_d    = first_ch;
            mask_d  = bus.ch_mask;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered outputs (decoded from next state).
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ch_q      <= '0;
      mask_q    <= '0;
      clr_q     <= 1'b0;
      gate_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      res_ch_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      clr_q   <= (state_d == StClear);
      gate_q  <= (state_d == StGate);
      valid_q <= (state_d == StOutput);
      busy_q  <= (state_d != StIdle);
      if (capture) begin
        res_cnt_q <= bus.meas_cnt;
        res_ch_q  <= ch_q;
      end
    end
  end

`ifdef PHASE_SCHED_TIMEOUT_EN
  // Sticky drop flag: set by an accept timeout, cleared by an accepted start.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (drop_clr) begin
      drop_q <= 1'b0;
    end else if (drop_set) begin
      drop_q <= 1'b1;
    end
  end
  assign bus.drop = drop_q;
`else
  assign bus.drop = 1'b0;
  logic unused_drop_clr;
  assign unused_drop_clr = drop_clr;
`endif

  assign bus.ch_sel    = ch_q;
  assign bus.meas_clr  = clr_q;
  assign bus.meas_gate = gate_q;
  assign bus.res_valid = valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_cnt   = res_cnt_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_phase_meas_sched.sv
// Scoreboard bench for phase_meas_sched (NUM_CH=4, S=3, G=8, CAP=2).
module tb_phase_meas_sched;

  localparam int unsigned NCH = 4;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] model_cnt = '0;
  res_t exp_q[$];
  int checks = 0;
  int failures = 0;

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_gate  = 1'b0;
  logic [1:0] prev_ch    = '0;

  always #5 clk = ~clk;

  phase_meas_sched_if #(.NUM_CH(NCH), .CNT_W(32)) sif ();

  phase_meas_sched #(
    .NUM_CH         (NCH),
    .SETTLE_CYCLES  (3),
    .GATE_CYCLES    (8),
    .CAP_CYCLES     (2),
    .CNT_W          (32),
    .TIMEOUT_CYCLES (5)
  ) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (sif.master)
  );

  // Datapath model: counts gate cycles, cleared by meas_clr.
  always @(posedge clk) begin
    if (sif.meas_clr) model_cnt <= '0;
    else if (sif.meas_gate) model_cnt <= model_cnt + 32'd1;
  end
  assign sif.meas_cnt = model_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (start sampled at the end of cycle 0).
  task automatic pulse_start();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  task automatic wait_valid(input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (!sif.res_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!sif.res_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_valid got=timeout expected=res_valid");
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sif.busy && n < 300) begin
      tick();
      n++;
    end
    chk(name, sif.busy, 0);
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] cnt);
    res_t r;
    r.ch  = ch;
    r.cnt = cnt;
    exp_q.push_back(r);
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_gate  <= 1'b0;
    end else begin
      if (sif.res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result got ch=%0d cnt=%0d expected=none",
                   sif.res_ch, sif.res_cnt);
        end else begin
          chk("res_ch", sif.res_ch, exp_q[0].ch);
          chk("res_cnt", sif.res_cnt, exp_q[0].cnt);
          if (sif.res_ready) void'(exp_q.pop_front());
        end
      end else if (prev_valid && !prev_ready && exp_q.size() > 0) begin
        // Result withdrawn without accept: dropped by timeout.
        void'(exp_q.pop_front());
      end
      if (sif.meas_gate) chk("clr_gate_exclusive", sif.meas_clr, 0);
      if (sif.meas_gate && prev_gate) chk("ch_sel_stable_in_gate", sif.ch_sel, prev_ch);
      prev_valid <= sif.res_valid;
      prev_ready <= sif.res_ready;
      prev_gate  <= sif.meas_gate;
      prev_ch    <= sif.ch_sel;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    sif.start     = 1'b0;
    sif.cont      = 1'b0;
    sif.ch_mask   = '0;
    sif.res_ready = 1'b0;
    tick();
    tick();
    // Reset values
    chk("rst_ch_sel", sif.ch_sel, 0);
    chk("rst_clr_gate", {sif.meas_clr, sif.meas_gate}, 0);
    chk("rst_valid", sif.res_valid, 0);
    chk("rst_res", {sif.res_ch, sif.res_cnt}, 0);
    chk("rst_busy_drop", {sif.busy, sif.drop}, 0);
    rst = 1'b0;
    tick();

    // Single sweep over channels 1 and 3
    sif.ch_mask   = 4'b1010;
    sif.res_ready = 1'b1;
    push(2'd1, 32'd8);
    push(2'd3, 32'd8);
    pulse_start();
    chk("s1_clear_cycle1", sif.meas_clr, 1);
    chk("s1_ch_sel_first", sif.ch_sel, 1);
    chk("s1_busy", sif.busy, 1);
    wait_valid(1, cyc);
    chk("s1_first_valid_cycle", cyc, 15);
    wait_idle("s1_idle");
    chk("s1_queue_empty", exp_q.size(), 0);
    tick();

    // Backpressure on channels 0 and 1
    sif.ch_mask   = 4'b0011;
    sif.res_ready = 1'b0;
    push(2'd0, 32'd8);
    push(2'd1, 32'd8);
    pulse_start();
    wait_valid(1, cyc);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid_held", sif.res_valid, 1);
      chk("bp_no_clear", sif.meas_clr, 0);
    end
    sif.res_ready = 1'b1;
    tick();
    chk("bp_valid_dropped_after_accept", sif.res_valid, 0);
    chk("bp_clear_after_accept", sif.meas_clr, 1);
    chk("bp_next_ch", sif.ch_sel, 1);
    wait_idle("bp_idle");
    chk("bp_queue_empty", exp_q.size(), 0);
    tick();

    // Empty mask: start ignored
    sif.ch_mask = 4'b0000;
    sif.start   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty_busy", sif.busy, 0);
      chk("empty_clr", sif.meas_clr, 0);
    end
    sif.start = 1'b0;
    tick();

    // Continuous wrap with a mid-gate mask change
    sif.cont    = 1'b1;
    sif.ch_mask = 4'b0001;
    push(2'd0, 32'd8);
    push(2'd2, 32'd8);
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    chk("cont_in_gate", sif.meas_gate, 1);
    sif.ch_mask = 4'b0100;
    wait_valid(6, cyc);
    tick();
    chk("cont_wrap_clear", sif.meas_clr, 1);
    chk("cont_wrap_ch", sif.ch_sel, 2);
    sif.cont = 1'b0;
    wait_idle("cont_idle");
    chk("cont_queue_empty", exp_q.size(), 0);
    tick();

    // Reset mid-gate, then replay
    sif.ch_mask = 4'b0001;
    pulse_start();
    for (int i = 0; i < 6; i++) tick();
    chk("rstg_gate_before", sif.meas_gate, 1);
    rst = 1'b1;
    #1;
    chk("rstg_gate_low", sif.meas_gate, 0);
    chk("rstg_busy_low", sif.busy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    push(2'd0, 32'd8);
    pulse_start();
    wait_valid(1, cyc);
    chk("rstg_replay_cycle", cyc, 15);
    wait_idle("rstg_idle");
    chk("rstg_queue_empty", exp_q.size(), 0);
    tick();

`ifdef PHASE_SCHED_TIMEOUT_EN
    // Accept timeout drops both results and sets drop
    sif.ch_mask   = 4'b0011;
    sif.res_ready = 1'b0;
    push(2'd0, 32'd8);
    push(2'd1, 32'd8);
    pulse_start();
    wait_valid(1, cyc);
    for (int i = 0; i < 4; i++) tick();
    chk("to_still_valid", sif.res_valid, 1);
    chk("to_no_drop_yet", sif.drop, 0);
    tick();
    chk("to_drop_set", sif.drop, 1);
    chk("to_valid_low", sif.res_valid, 0);
    chk("to_advanced", {sif.meas_clr, sif.ch_sel}, 3'b101);
    wait_idle("to_idle");
    chk("to_drop_sticky", sif.drop, 1);
    chk("to_queue_empty", exp_q.size(), 0);
    sif.ch_mask   = 4'b0001;
    sif.res_ready = 1'b1;
    push(2'd0, 32'd8);
    pulse_start();
    chk("to_drop_cleared", sif.drop, 0);
    wait_idle("to_idle2");
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
